// File: rtl/piso_serializer_if.sv
// ---------------------------------------------------------------------------
// piso_serializer_if
// Bundles the signals that connect the parallel-to-serial stage to its
// producer and to the downstream serial consumer.
//   in_data  [WIDTH] parallel word offered by the producer
//   in_valid         in_data is valid
//   in_ready         serializer can take a word this cycle
//   shift_en         downstream advance-one-bit enable
//   so               serial data out
//   so_valid         so carries a data bit this cycle
//   busy             a frame is shifting or a word is waiting
//   done             one-cycle pulse after the last bit of a word
// The master modport is the environment (producer and consumer side); the
// slave modport is the serializer itself.
// ---------------------------------------------------------------------------
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             shift_en;
    logic             so;
    logic             so_valid;
    logic             busy;
    logic             done;

    modport master (
        output in_data,
        output in_valid,
        output shift_en,
        input  in_ready,
        input  so,
        input  so_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  shift_en,
        output in_ready,
        output so,
        output so_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Parallel-in/serial-out stage. Words arrive over a valid/ready handshake
// into a one-word holding buffer, are moved into a shift register and leave
// one bit per enabled clock on `so`. If the holding buffer is refilled before
// the last bit of the current word, the next word follows with no gap bit.
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous, active-high reset
//   bus    piso_serializer_if slave modport (handshake, shift enable and
//          serial outputs)
// Parameters:
//   WIDTH       word width in bits (>= 2)
//   LSB_FIRST   1: bit 0 leaves first, 0: bit WIDTH-1 leaves first
//   IDLE_LEVEL  level driven on so when no frame is active
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    piso_serializer_if.slave   bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [WIDTH-1:0]   hold_r;
    logic               hold_valid_r;
    logic [WIDTH-1:0]   shreg_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               done_r;

    logic               accept_s;
    logic               step_s;
    logic               last_s;
    logic               load_s;
    logic               so_s;
    logic               so_valid_s;

    // Handshake and datapath control decodes
    always_comb begin
        accept_s = bus.in_valid && !hold_valid_r;
        step_s   = (state_r == ST_SHIFT) && bus.shift_en;
        last_s   = (cnt_r == CNT_LAST);
        // Load from the holding buffer either to start a frame from IDLE or
        // to chain the next word right behind the last bit of this one.
        // Accept needs the buffer empty and load needs it full, so the two
        // never happen on the same edge.
        load_s   = hold_valid_r &&
                   ((state_r == ST_IDLE) || (step_s && last_s));
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hold_valid_r) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (step_s && last_s && !hold_valid_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic; only flops feed so/so_valid
    always_comb begin
        so_s       = IDLE_LEVEL;
        so_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                so_s       = IDLE_LEVEL;
                so_valid_s = 1'b0;
            end
            ST_SHIFT: begin
                if (LSB_FIRST) begin
                    so_s = shreg_r[0];
                end else begin
                    so_s = shreg_r[WIDTH-1];
                end
                so_valid_s = 1'b1;
            end
            default: begin
                so_s       = IDLE_LEVEL;
                so_valid_s = 1'b0;
            end
        endcase
    end

    // Holding buffer: filled on accept, emptied when moved into the shifter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_r       <= {WIDTH{1'b0}};
            hold_valid_r <= 1'b0;
        end else if (accept_s) begin
            hold_r       <= bus.in_data;
            hold_valid_r <= 1'b1;
        end else if (load_s) begin
            hold_valid_r <= 1'b0;
        end else begin
            hold_valid_r <= hold_valid_r;
        end
    end

    // Shift register and bit counter; frozen whenever shift_en is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (load_s) begin
            shreg_r <= hold_r;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (step_s && !last_s) begin
            // Move the next bit toward the end that drives so
            if (LSB_FIRST) begin
                shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
            end else begin
                shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
            end
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
        end
    end

    // Frame-complete pulse, raised for the cycle after the last bit's shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r <= 1'b0;
        end else begin
            done_r <= step_s && last_s;
        end
    end

    assign bus.in_ready = !hold_valid_r;
    assign bus.so       = so_s;
    assign bus.so_valid = so_valid_s;
    assign bus.busy     = (state_r == ST_SHIFT) || hold_valid_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
// Directed bench for piso_serializer (WIDTH=8, LSB first, idle level 0).
// A 4-stage serial delay register models the downstream consumer of so.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [3:0] siso_r;

    piso_serializer_if #(.WIDTH(8)) bus ();

    piso_serializer #(
        .WIDTH      (8),
        .LSB_FIRST  (1'b1),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 4-stage serial delay register fed by so
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            siso_r <= 4'b0000;
        end else begin
            siso_r <= {siso_r[2:0], bus.so};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one word from idle with shift_en=1. seq[j] is the j-th bit
    // expected on so, written in transmission order.
    task automatic run_word(input logic [7:0] w, input logic [0:7] seq);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        bus.shift_en = 1'b1;
        @(negedge clk);
        check("acc_ready_low", 32'(bus.in_ready), 32'd0);
        check("acc_not_yet_valid", 32'(bus.so_valid), 32'd0);
        bus.in_valid = 1'b0;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (j < 8) begin
                check("word_so", 32'(bus.so), 32'(seq[j]));
                check("word_so_valid", 32'(bus.so_valid), 32'd1);
                check("word_no_done", 32'(bus.done), 32'd0);
            end
            if (j >= 4 && j < 12) begin
                check("siso_out", 32'(siso_r[3]), 32'(seq[j-4]));
            end
            if (j == 8) begin
                check("word_done", 32'(bus.done), 32'd1);
                check("word_idle_so", 32'({bus.so, bus.so_valid}), 32'd0);
            end
            if (j == 9) begin
                check("word_done_once", 32'(bus.done), 32'd0);
                check("word_busy_clear", 32'(bus.busy), 32'd0);
            end
        end
    endtask

    initial begin
        logic [7:0] words [3];
        logic [23:0] bits;
        int idx;
        int stall;
        int nbits;
        int ndone;
        logic rdy_prev;

        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b1;    // must be ignored while reset is high
        bus.shift_en = 1'b0;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b0;

        // 1. reset then idle
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_outputs", 32'({bus.so, bus.so_valid, bus.in_ready, bus.busy, bus.done}),
                  32'b00100);
        end

        // 2. single word 0xB4 -> 0,0,1,0,1,1,0,1
        run_word(8'hB4, 8'b0010_1101);

        // 3. back-to-back 0xFF then 0x00
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        bus.shift_en = 1'b1;
        @(negedge clk);
        bus.in_data = 8'h00;
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            check("b2b_so_valid", 32'(bus.so_valid), 32'(j < 16));
            check("b2b_so", 32'(bus.so), 32'(j < 8));
            check("b2b_done", 32'(bus.done), 32'((j == 8) || (j == 16)));
            check("b2b_in_ready", 32'(bus.in_ready), 32'((j == 0) || (j >= 8)));
            if (j == 1) begin
                bus.in_valid = 1'b0;
            end
        end

        // 4. stall: shift_en alternates, 0xA5 -> 1,0,1,0,0,1,0,1
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        bus.shift_en = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 0; c < 18; c++) begin
            logic [0:7] seq;
            seq = 8'b1010_0101;
            @(negedge clk);
            if (c < 16) begin
                check("stall_so", 32'(bus.so), 32'(seq[c/2]));
                check("stall_so_valid", 32'(bus.so_valid), 32'd1);
                check("stall_no_done", 32'(bus.done), 32'd0);
            end else begin
                check("stall_done", 32'(bus.done), 32'(c == 16));
                check("stall_idle", 32'(bus.so_valid), 32'd0);
            end
            bus.shift_en = (c % 2 == 1);
        end
        bus.shift_en = 1'b1;

        // 5. backpressure with three words queued and in_valid held high
        words[0] = 8'h5A;
        words[1] = 8'hC3;
        words[2] = 8'h96;
        idx   = 0;
        stall = 0;
        nbits = 0;
        ndone = 0;
        bits  = 24'h000000;
        bus.in_data  = words[0];
        bus.in_valid = 1'b1;
        rdy_prev     = bus.in_ready;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.in_valid && rdy_prev) begin
                idx++;
            end
            if (bus.so_valid) begin
                if (nbits < 24) begin
                    bits[nbits] = bus.so;
                end
                nbits++;
            end
            if (bus.done) begin
                ndone++;
            end
            bus.in_valid = (idx < 3);
            bus.in_data  = (idx < 3) ? words[idx] : 8'h00;
            if (bus.in_valid && !bus.in_ready) begin
                stall++;
            end
            rdy_prev = bus.in_ready;
        end
        check("bp_accepted", 32'(idx), 32'd3);
        check("bp_stall_cycles", 32'(stall), 32'd8);
        check("bp_bit_count", 32'(nbits), 32'd24);
        check("bp_done_count", 32'(ndone), 32'd3);
        check("bp_word0", 32'(bits[7:0]), 32'h5A);
        check("bp_word1", 32'(bits[15:8]), 32'hC3);
        check("bp_word2", 32'(bits[23:16]), 32'h96);

        // 6. reset mid-frame: 0x3C shifting (0,0,1,1,...) with 0x81 held
        bus.in_data  = 8'h3C;
        bus.in_valid = 1'b1;
        bus.shift_en = 1'b1;
        @(negedge clk);
        bus.in_data = 8'h81;
        @(negedge clk);
        check("mid_bit0", 32'(bus.so), 32'd0);
        check("mid_ready_before_hold", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("mid_bit1", 32'(bus.so), 32'd0);
        check("mid_held", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("mid_bit2", 32'(bus.so), 32'd1);
        @(negedge clk);
        check("mid_bit3", 32'(bus.so), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_outputs", 32'({bus.so, bus.so_valid, bus.in_ready, bus.busy, bus.done}),
              32'b00100);
        @(negedge clk);
        check("rst_hold_outputs", 32'({bus.so, bus.so_valid, bus.in_ready, bus.busy, bus.done}),
              32'b00100);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_discard_held", 32'({bus.so_valid, bus.busy, bus.done}), 32'd0);
        end
        // 0xC5 -> 1,0,1,0,0,0,1,1
        run_word(8'hC5, 8'b1010_0011);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Bound the whole run in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
